// File: rtl/checkout_pkg.sv
// Shared types and constants for the checkout sequencer: FSM states and the item price table.
package checkout_pkg;

  typedef enum logic [1:0] {IDLE, SCANNING, LOOKUP, COMPLETE} state_e;

  localparam int TABLE_CODE_W  = 4;
  localparam int INVALID_PRICE = 0;
  localparam int DISCOUNT_CODE = 5;

  // Codes without a special price are charged ten units per code value; 0 and 15 are unassigned.
  localparam logic [7:0] PRICE_TABLE [2**TABLE_CODE_W] = '{
    8'd0,   8'd12,  8'd25,  8'd7,   8'd40,  8'd40,  8'd65,  8'd70,
    8'd80,  8'd90,  8'd100, 8'd110, 8'd120, 8'd130, 8'd140, 8'd0
  };

endpackage

// File: rtl/checkout_price_rom.sv
// Combinational code-to-price lookup. With CHECKOUT_DISCOUNT_EN defined, the discount
// item is charged half its table price.
module checkout_price_rom
  import checkout_pkg::*;
#(
  parameter int CODE_W  = 4,
  parameter int PRICE_W = 8
) (
  input  logic [CODE_W-1:0]  code_i,
  output logic [PRICE_W-1:0] price_o,
  output logic               valid_o
);

  logic [PRICE_W-1:0] base_price;

  always_comb begin
    base_price = PRICE_W'(PRICE_TABLE[code_i]);
`ifdef CHECKOUT_DISCOUNT_EN
    price_o = (code_i == CODE_W'(DISCOUNT_CODE)) ? (base_price >> 1) : base_price;
`else
    price_o = base_price;
`endif
    valid_o = (price_o != PRICE_W'(INVALID_PRICE));
  end

endmodule

// File: rtl/checkout_controller.sv
// Checkout sequencer: scan -> one-cycle price lookup -> saturating running total and item count.
// Optional half-price item via CHECKOUT_DISCOUNT_EN (handled inside checkout_price_rom).
module checkout_controller
  import checkout_pkg::*;
#(
  parameter int CODE_W    = 4,
  parameter int PRICE_W   = 8,
  parameter int TOTAL_W   = 12,
  parameter int MAX_ITEMS = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [CODE_W-1:0]  code_i,
  input  logic               scan_i,
  input  logic               done_i,
  input  logic               clear_i,
  output logic [TOTAL_W-1:0] total_o,
  output logic [3:0]         count_o,
  output logic [PRICE_W-1:0] last_price_o,
  output logic               busy_o,
  output logic               invalid_o,
  output logic               full_o,
  output logic               receipt_valid_o
);

  state_e             state_q, state_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic [TOTAL_W-1:0] total_q, total_d;
  logic [3:0]         count_q, count_d;
  logic [PRICE_W-1:0] last_q, last_d;
  logic [PRICE_W-1:0] rom_price;
  logic               rom_valid;
  logic [TOTAL_W:0]   sum;
  logic               full;

  checkout_price_rom #(.CODE_W(CODE_W), .PRICE_W(PRICE_W)) u_rom (
    .code_i  (code_q),
    .price_o (rom_price),
    .valid_o (rom_valid)
  );

  assign full = (count_q == 4'(MAX_ITEMS));
  // One extra bit catches the carry so the total can pin at all-ones instead of wrapping.
  assign sum  = {1'b0, total_q} + (TOTAL_W+1)'(rom_price);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      code_q  <= '0;
      total_q <= '0;
      count_q <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      total_q <= total_d;
      count_q <= count_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    total_d = total_q;
    count_d = count_q;
    last_d  = last_q;
    if (clear_i) begin
      state_d = IDLE;
      total_d = '0;
      count_d = '0;
      last_d  = '0;
    end else begin
      case (state_q)
        IDLE: if (scan_i) begin
          state_d = LOOKUP;
          code_d  = code_i;
        end
        SCANNING: begin
          if (done_i) begin
            state_d = COMPLETE;
          end else if (scan_i && !full) begin
            state_d = LOOKUP;
            code_d  = code_i;
          end
        end
        LOOKUP: begin
          if (rom_valid) begin
            total_d = sum[TOTAL_W] ? '1 : sum[TOTAL_W-1:0];
            count_d = count_q + 4'd1;
            last_d  = rom_price;
            state_d = SCANNING;
          end else begin
            state_d = (count_q == 4'd0) ? IDLE : SCANNING;
          end
        end
        COMPLETE: if (done_i) begin
          state_d = IDLE;
          total_d = '0;
          count_d = '0;
          last_d  = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign total_o         = total_q;
  assign count_o         = count_q;
  assign last_price_o    = last_q;
  assign busy_o          = (state_q == LOOKUP);
  assign invalid_o       = (state_q == LOOKUP) && !rom_valid;
  assign full_o          = full;
  assign receipt_valid_o = (state_q == COMPLETE);

endmodule

// File: tb/tb_checkout_controller.sv
// Bench for checkout_controller: item-list model checked every cycle, plus directed literal checks.
// Two instances share stimulus: default widths and an 8-bit total for saturation.
module tb_checkout_controller;

  logic        clk, reset, scan, done, clear;
  logic [3:0]  code;
  logic [11:0] total;
  logic [7:0]  total8;
  logic [3:0]  count, count8;
  logic [7:0]  last, last8;
  logic        busy, busy8, inv, inv8, full, full8, rcpt, rcpt8;

  int checks = 0, errors = 0;
  int inv_cnt = 0, busy_cnt = 0;
  bit started = 0;

  checkout_controller dut (
    .clk(clk), .reset(reset), .code_i(code), .scan_i(scan), .done_i(done), .clear_i(clear),
    .total_o(total), .count_o(count), .last_price_o(last), .busy_o(busy),
    .invalid_o(inv), .full_o(full), .receipt_valid_o(rcpt)
  );

  checkout_controller #(.TOTAL_W(8)) dut8 (
    .clk(clk), .reset(reset), .code_i(code), .scan_i(scan), .done_i(done), .clear_i(clear),
    .total_o(total8), .count_o(count8), .last_price_o(last8), .busy_o(busy8),
    .invalid_o(inv8), .full_o(full8), .receipt_valid_o(rcpt8)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: the transaction is the list of accepted prices plus a few flags.
  int  items[$];
  bit  m_pending, m_receipt;
  int  m_code;

  function automatic int price_of(input int c);
    case (c)
      0, 15: return 0;
      1:  return 12;
      2:  return 25;
      3:  return 7;
`ifdef CHECKOUT_DISCOUNT_EN
      5:  return 20;
`else
      5:  return 40;
`endif
      6:  return 65;
      default: return 10 * c;
    endcase
  endfunction

  function automatic int sum_sat(input int lim);
    int s = 0;
    foreach (items[i]) s += items[i];
    return (s > lim) ? lim : s;
  endfunction

  always @(posedge clk) begin
    if (reset || (clear && started)) begin
      items.delete(); m_pending = 0; m_receipt = 0;
    end else if (m_pending) begin
      if (price_of(m_code) != 0) items.push_back(price_of(m_code));
      m_pending = 0;
    end else if (m_receipt) begin
      if (done) begin items.delete(); m_receipt = 0; end
    end else if (done && items.size() > 0) begin
      m_receipt = 1;
    end else if (scan && items.size() < 15) begin
      m_pending = 1; m_code = int'(code);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      automatic int lp = (items.size() > 0) ? items[items.size()-1] : 0;
      automatic bit ex_inv = m_pending && (price_of(m_code) == 0);
      chk("total",   total,  sum_sat(4095));
      chk("total8",  total8, sum_sat(255));
      chk("count",   count,  items.size());
      chk("count8",  count8, items.size());
      chk("last",    last,   lp);
      chk("busy",    busy,   m_pending);
      chk("invalid", inv,    ex_inv);
      chk("invalid8", inv8,  ex_inv);
      chk("full",    full,   items.size() == 15);
      chk("receipt", rcpt,   m_receipt);
      if (inv)  inv_cnt++;
      if (busy) busy_cnt++;
    end
  end

  task automatic scan_item(input int c);
    @(posedge clk); #2 scan = 1; code = 4'(c);
    @(posedge clk); #2 scan = 0;
    @(posedge clk); #2;
  endtask

  task automatic pulse_done();
    @(posedge clk); #2 done = 1;
    @(posedge clk); #2 done = 0;
  endtask

  task automatic pulse_clear();
    @(posedge clk); #2 clear = 1;
    @(posedge clk); #2 clear = 0;
  endtask

  initial begin
    reset = 1; scan = 0; done = 0; clear = 0; code = 0;
    repeat (3) @(posedge clk);
    #2 reset = 0; started = 1;
    chk("reset_total", total, 0);
    chk("reset_count", count, 0);
    chk("reset_flags", {busy, inv, full, rcpt}, 0);

    scan_item(2);
    chk("scan2_total", total, 25);
    chk("scan2_count", count, 1);
    chk("scan2_last",  last, 25);

    pulse_clear();
    scan_item(1); scan_item(3); scan_item(6);
    pulse_done();
    chk("done_total", total, 84);
    chk("done_count", count, 3);
    chk("done_receipt", rcpt, 1);
    scan_item(4);
    chk("complete_scan_ignored", count, 3);
    pulse_done();
    chk("close_total", total, 0);
    chk("close_receipt", rcpt, 0);

    inv_cnt = 0;
    scan_item(0); scan_item(15);
    chk("invalid_pulses", inv_cnt, 2);
    chk("invalid_total", total, 0);
    chk("invalid_count", count, 0);

    repeat (15) scan_item(14);
    chk("full_count", count, 15);
    chk("full_flag", full, 1);
    chk("full_total", total, 2100);
    inv_cnt = 0; busy_cnt = 0;
    scan_item(14);
    chk("full_scan_count", count, 15);
    chk("full_scan_invalid", inv_cnt, 0);
    chk("full_scan_busy", busy_cnt, 0);
    pulse_done(); pulse_done();

    repeat (4) scan_item(6);
    chk("sat_total8", total8, 255);
    chk("sat_count8", count8, 4);
    chk("nosat_total", total, 260);
    @(posedge clk); #2 clear = 1; done = 1;
    @(posedge clk); #2 clear = 0; done = 0;
    chk("clr_done_total", total, 0);
    chk("clr_done_count", count, 0);
    chk("clr_done_receipt", rcpt, 0);

    scan_item(5);
`ifdef CHECKOUT_DISCOUNT_EN
    chk("code5_total", total, 20);
`else
    chk("code5_total", total, 40);
`endif
    @(posedge clk); #2 scan = 1; code = 4'd3;
    @(posedge clk); #2;
    @(posedge clk); #2 scan = 0;
    @(posedge clk); #2;
    chk("lookup_drop_count", count, 2);
`ifdef CHECKOUT_DISCOUNT_EN
    chk("lookup_drop_total", total, 27);
`else
    chk("lookup_drop_total", total, 47);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/checkout_controller.md
Name: checkout_controller

Overview:
- Sequencer for the department-store checkout datapath.
- Accepts one scanned item code per scan pulse, looks up its price, and accumulates a running total and item count.
- Closes the transaction on a done pulse.
- Sits between the debounced KEY/SW front end and the HEX/LEDR display logic in DE1_SoC. Board-level glue feeds `code_i` from SW[3:0].

Parameters:
- CODE_W, 4, item code width.
- PRICE_W, 8, price width (unsigned, whole units).
- TOTAL_W, 12, running total width.
- MAX_ITEMS, 15, maximum items per transaction; must fit in 4 bits.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- code_i  in  CODE_W  item code, sampled only on the cycle scan_i is high.
- scan_i  in  1  single-cycle scan pulse (pre-debounced, edge-detected).
- done_i  in  1  single-cycle checkout-complete pulse.
- clear_i  in  1  single-cycle transaction abort/clear pulse.
- total_o  out  TOTAL_W  running total.
- count_o  out  4  accepted item count.
- last_price_o  out  PRICE_W  price of the last accepted item.
- busy_o  out  1  high in LOOKUP.
- invalid_o  out  1  one-cycle pulse when a scanned code is invalid.
- full_o  out  1  count_o == MAX_ITEMS.
- receipt_valid_o  out  1  high in COMPLETE.

Behaviour:
- Reset: state = IDLE; total_o = 0, count_o = 0, last_price_o = 0; all flags 0. Reset overrides every input.
- States and transitions:
  - IDLE: scan_i → LOOKUP. done_i is ignored.
  - SCANNING: scan_i with !full_o → LOOKUP. done_i → COMPLETE.
  - LOOKUP: lasts exactly 1 cycle; scan_i and done_i arriving here are dropped.
    - Valid price: total += price, count += 1, last_price_o = price, go to SCANNING.
    - Invalid price: invalid_o pulses for 1 cycle, totals are unchanged, return to the prior state (IDLE if count == 0, else SCANNING).
  - COMPLETE: holds total/count; scan_i is ignored; done_i or clear_i → IDLE with totals cleared.
- Latency: code is registered on the scan cycle; total_o/count_o update 2 cycles after the scan pulse (edge N+2).
- clear_i: in any state, → IDLE with totals zeroed on the next edge. Priority is clear_i > done_i > scan_i.
- Full: when count_o == MAX_ITEMS, scans in SCANNING are ignored (no LOOKUP, no invalid_o); done_i is still accepted.
- Arithmetic:
  - Price is zero-extended to TOTAL_W.
  - Total saturates at 2^TOTAL_W−1 and never wraps; the item is still counted.
- Price table (combinational, from package), code → price:
  - 0 → invalid (price 0)
  - 1 → 12
  - 2 → 25
  - 3 → 7
  - 5 → 40
  - 6 → 65
  - 15 → invalid
  - any other code c → 10·c
  - A price of 0 means invalid.

Optional Feature:
- Macro: CHECKOUT_DISCOUNT_EN.
- Defined: item code 5 is charged price>>1 (40 → 20). last_price_o reports the charged price.
- Undefined: every item is charged the full table price; no discount logic is synthesized.

Decomposition:
- Package checkout_pkg holds:
  - state enum {IDLE, SCANNING, LOOKUP, COMPLETE};
  - PRICE_TABLE constant array;
  - INVALID_PRICE = 0;
  - DISCOUNT_CODE = 5.
- Sub-module checkout_price_rom: code in → price and valid out, purely combinational, discount applied inside under the macro.

Test Plan:
- Reset, then scan code 2 → at edge N+2, total_o = 25, count_o = 1, state SCANNING, last_price_o = 25.
- Scans of 1, 3, 6, then done_i → total_o = 84, count_o = 3, receipt_valid_o = 1; a further scan of 4 is ignored; done_i → IDLE with total_o = 0.
- Scan code 0 and code 15 from IDLE → invalid_o pulses once each, total_o = 0, count_o = 0, state remains IDLE.
- 15 scans of code 14, then a 16th scan:
  - full_o = 1 and count_o = 15;
  - total_o = 2100;
  - the 16th scan is ignored and no invalid_o pulse occurs.
- Saturation: with TOTAL_W = 8, scans 6, 6, 6, 6 → total_o = 255, count_o = 4. Separately, clear_i and done_i asserted on the same cycle in SCANNING → IDLE, totals 0.
- Scan code 5: total_o = 40 without CHECKOUT_DISCOUNT_EN, 20 with it. A scan pulse in the LOOKUP cycle is dropped (count_o increments only once).
